// File: rtl/div_unit_if.sv
// Issue/writeback bundle for the iterative divider: request side in, result side out.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;

  modport master (
    output valid_i, op_i, operand_a_i, operand_b_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, op_i, operand_a_i, operand_b_i, flush_i, ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU: restoring divider on magnitudes, one quotient bit per cycle,
// sign fix-up applied combinationally while the result is presented.
module div_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             is_rem_q, is_rem_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] result_c;

  always_comb begin
    signed_op = ~bus.op_i[0];
    a_neg     = signed_op & bus.operand_a_i[WIDTH-1];
    b_neg     = signed_op & bus.operand_b_i[WIDTH-1];
    abs_a     = a_neg ? -bus.operand_a_i : bus.operand_a_i;
    abs_b     = b_neg ? -bus.operand_b_i : bus.operand_b_i;
    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
    rem_sh    = {rem_q, quot_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, b_q};
    if (is_rem_q) result_c = rem_neg_q ? -rem_q : rem_q;
    else          result_c = quot_neg_q ? -quot_q : quot_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    b_d        = b_q;
    last_d     = last_q;
    is_rem_d   = is_rem_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          is_rem_d = bus.op_i[1];
          b_d      = abs_b;
          if (bus.operand_b_i == '0) begin
            // Special results are stored final, so the sign fix-up is disabled.
            quot_d     = '1;
            rem_d      = bus.operand_a_i;
            quot_neg_d = 1'b0;
            rem_neg_d  = 1'b0;
            state_d    = DONE;
          end else if (signed_op && bus.operand_a_i == {1'b1, {(WIDTH-1){1'b0}}}
                       && bus.operand_b_i == '1) begin
            quot_d     = {1'b1, {(WIDTH-1){1'b0}}};
            rem_d      = '0;
            quot_neg_d = 1'b0;
            rem_neg_d  = 1'b0;
            state_d    = DONE;
          end else begin
            rem_d      = '0;
            quot_d     = abs_a;
            quot_neg_d = a_neg ^ b_neg;
            rem_neg_d  = a_neg;
            cnt_d      = CNT_W'(WIDTH-1);
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) rem_d = trial[WIDTH-1:0];
        else               rem_d = rem_sh[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d = cnt_q - 1'b1;
      end
      DONE: begin
        if (bus.ready_i) begin
          last_d  = result_c;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush_i) begin
      state_d = IDLE;
      if (state_q == DONE) last_d = result_c;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      b_q        <= '0;
      last_q     <= '0;
      is_rem_q   <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      b_q        <= b_d;
      last_q     <= last_d;
      is_rem_q   <= is_rem_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end

  assign bus.ready_o  = (state_q == IDLE);
  assign bus.valid_o  = (state_q == DONE);
  assign bus.result_o = (state_q == DONE) ? result_c : last_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results queued at issue, checked by a monitor on handshake.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per completed output handshake.
  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("result", bus.result_o, e);
        $display("result 0x%08h expected 0x%08h", bus.result_o, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready_o && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", 32'(bus.ready_o), 32'd1);
  endtask

  // Issue one op, push its expected result and check the latency in edges after accept.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_edges,
                       input bit push);
    int edges = 0;
    wait_ready();
    bus.op_i = op; bus.operand_a_i = a; bus.operand_b_i = b; bus.valid_i = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.operand_a_i = 32'hDEAD_BEEF; bus.operand_b_i = 32'h1234_5678; bus.op_i = ~op;
    if (exp_edges < 0) return;
    while (!bus.valid_o && edges < 100) begin
      @(posedge clk); #1; edges++;
    end
    check({name, "_latency"}, 32'(edges), 32'(exp_edges));
    $display("op %s a=0x%08h b=0x%08h edges=%0d", name, a, b, edges);
    if (bus.ready_i) begin
      @(posedge clk); #1;
      check({name, "_release"}, {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
    end
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.op_i = 2'b00; bus.operand_a_i = '0; bus.operand_b_i = '0;
    bus.flush_i = 1'b0; bus.ready_i = 1'b1;
    #12;
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_ready", 32'(bus.ready_o), 32'd1);
    check("reset_result", bus.result_o, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    issue("DIVU_100_7",  2'b01, 32'd100,       32'd7,         32'd14,        32, 1);
    issue("REMU_100_7",  2'b11, 32'd100,       32'd7,         32'd2,         32, 1);
    issue("DIV_m7_2",    2'b00, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32, 1);
    issue("REM_m7_2",    2'b10, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32, 1);
    issue("DIV_7_m2",    2'b00, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32, 1);
    issue("REM_7_m2",    2'b10, 32'd7,         32'hFFFFFFFE,  32'd1,         32, 1);
    issue("DIVU_5_0",    2'b01, 32'd5,         32'd0,         32'hFFFFFFFF,  0,  1);
    issue("REM_5_0",     2'b10, 32'd5,         32'd0,         32'd5,         0,  1);
    issue("DIV_m1_0",    2'b00, 32'hFFFFFFFF,  32'd0,         32'hFFFFFFFF,  0,  1);
    issue("DIV_ovf",     2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  0,  1);
    issue("REM_ovf",     2'b10, 32'h80000000,  32'hFFFFFFFF,  32'd0,         0,  1);
    issue("DIVU_max_1",  2'b01, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32, 1);
    issue("REMU_max_16", 2'b11, 32'hFFFFFFFF,  32'h10,        32'hF,         32, 1);

    // Backpressure: result must stay put while writeback stalls.
    bus.ready_i = 1'b0;
    issue("DIVU_bp", 2'b01, 32'd1000, 32'd10, 32'd100, 32, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {bus.result_o[29:0], bus.valid_o, bus.ready_o}, {30'd100, 1'b1, 1'b0});
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
    issue("DIV_after_bp", 2'b00, 32'h80000000, 32'd2, 32'hC0000000, 32, 1);

    // Flush at iteration 10: no result must appear afterwards.
    issue("DIVU_flush", 2'b01, 32'd100, 32'd7, 32'd0, -1, 0);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_state", {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
    repeat (40) begin
      @(posedge clk); #1;
      check("flush_no_valid", 32'(bus.valid_o), 32'd0);
    end

    // Flush together with a request: a divide-by-zero would show valid immediately if taken.
    bus.op_i = 2'b01; bus.operand_a_i = 32'd9; bus.operand_b_i = 32'd0;
    bus.valid_i = 1'b1; bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    check("flush_accept_blocked", {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
    @(posedge clk); #1;
    check("flush_accept_idle", 32'(bus.valid_o), 32'd0);

    // Asynchronous reset mid-calculation; last result 0xC0000000 must be cleared.
    issue("DIVU_rst", 2'b01, 32'd100, 32'd7, 32'd0, -1, 0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_result", bus.result_o, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    issue("REMU_post_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32, 1);

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
